// File: rtl/spi_frame_rx.sv
// spi_frame_rx: SPI mode-0 receiver for 16-bit write frames.
// A frame is {rw, addr[6:0], data[7:0]}, sent MSB first. Every SPI pin is
// resynchronised into the clk domain before any logic reads it.
module spi_frame_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [2:0] SETTLE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
    logic                   sclk_dly_q, copi_dly_q, ncs_dly_q;
    logic                   sclk_s, ncs_s;
    logic                   sclk_rise, ncs_rise, ncs_fall;

    logic [2:0]  settle_q;
    logic        armed_q;

    state_t      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  count_q, count_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    // Synchronizer chains plus one edge-detect flop per SPI input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_dly_q  <= 1'b0;
            copi_dly_q  <= 1'b0;
            ncs_dly_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
            copi_dly_q  <= copi_sync_q[SYNC_STAGES-1];
            ncs_dly_q   <= ncs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign ncs_rise  = ncs_s & ~ncs_dly_q;
    assign ncs_fall  = ~ncs_s & ncs_dly_q;

    // Arm frame start only once the chains have flushed the reset value and
    // ncs is genuinely high, so a frame already running at reset release is
    // skipped until its ncs has risen and fallen again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            if (settle_q != SETTLE) begin
                settle_q <= settle_q + 3'd1;
            end
            if (settle_q == SETTLE && ncs_s && ncs_dly_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    // FSM and datapath state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            count_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Next-state: shift on sclk rise, evaluate the frame on ncs rise.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (armed_q && ncs_fall) begin
                    state_d = SHIFT;
                    shift_d = '0;
                    count_d = '0;
                end
            end
            SHIFT: begin
                // ncs rise wins over a coincident sclk rise.
                if (ncs_rise) begin
                    state_d = IDLE;
                    if (count_q == 5'd16) begin
                        if (shift_q[15]) begin
                            valid_d = 1'b1;
                            addr_d  = shift_q[14:8];
                            data_d  = shift_q[7:0];
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (sclk_rise && !ncs_s) begin
                    shift_d = {shift_q[14:0], copi_dly_q};
                    if (count_q != 5'd17) begin
                        count_d = count_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_valid  = valid_q;
    assign frame_err = err_q;
    assign wr_addr   = addr_q;
    assign wr_data   = data_q;
    assign busy      = (state_q == SHIFT);

endmodule
